// File: rtl/dot_product_seq.sv
// Dot-product sequencer: streams operand pairs through an external combinational
// 24-bit ALU (ZERO, then MUL/ADD per pair, optional SFTR) and returns the sum.
module dot_product_seq #(
  parameter int DATA_W = 24,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              shift_en,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              zero_flag,
  output logic              op_req,
  input  logic              op_valid,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [2:0]        alu_ctrl,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_c,
  input  logic              alu_z
);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_SFTR = 3'd4;
  localparam logic [2:0] OP_ZERO = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_FETCH = 3'd2,
    S_MUL   = 3'd3,
    S_ACC   = 3'd4,
    S_SHIFT = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               shift_q, shift_d;
  logic [DATA_W-1:0]  a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0]  prod_q, prod_d, acc_q, acc_d;
  logic               accz_q, accz_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               zflag_q, zflag_d;

  // Next-state and datapath capture; the ALU result is consumed in the same cycle it is requested.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    a_d      = a_q;
    b_d      = b_q;
    prod_d   = prod_q;
    acc_d    = acc_q;
    accz_d   = accz_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    zflag_d  = zflag_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = len;
          shift_d = shift_en;
          busy_d  = 1'b1;
          state_d = S_CLR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLR: begin
        acc_d  = alu_c;
        accz_d = alu_z;
        if (cnt_q == '0) begin
          state_d = shift_q ? S_SHIFT : S_FIN;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (op_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          state_d = S_MUL;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MUL: begin
        prod_d  = alu_c;
        state_d = S_ACC;
      end
      S_ACC: begin
        acc_d  = alu_c;
        accz_d = alu_z;
        cnt_d  = cnt_q - LEN_W'(1);
        if (cnt_q == LEN_W'(1)) begin
          state_d = shift_q ? S_SHIFT : S_FIN;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_SHIFT: begin
        acc_d   = alu_c;
        accz_d  = alu_z;
        state_d = S_FIN;
      end
      S_FIN: begin
        result_d = acc_q;
        zflag_d  = accz_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shift_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      acc_q    <= '0;
      accz_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      zflag_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      a_q      <= a_d;
      b_q      <= b_d;
      prod_q   <= prod_d;
      acc_q    <= acc_d;
      accz_q   <= accz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      zflag_q  <= zflag_d;
    end
  end

  // ALU command and operand request decode from the registered state.
  always_comb begin
    op_req   = 1'b0;
    alu_ctrl = OP_NOP;
    alu_a    = '0;
    alu_b    = '0;
    case (state_q)
      S_CLR:   alu_ctrl = OP_ZERO;
      S_FETCH: op_req   = 1'b1;
      S_MUL: begin
        alu_ctrl = OP_MUL;
        alu_a    = a_q;
        alu_b    = b_q;
      end
      S_ACC: begin
        alu_ctrl = OP_ADD;
        alu_a    = acc_q;
        alu_b    = prod_q;
      end
      S_SHIFT: begin
        alu_ctrl = OP_SFTR;
        alu_a    = acc_q;
      end
      default: alu_ctrl = OP_NOP;
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign zero_flag = zflag_q;

endmodule

// File: tb/tb_dot_product_seq.sv
// Randomized bench for dot_product_seq: behavioural ALU, arithmetic dot-product
// reference, latency/handshake/hold checks per job.
module tb_dot_product_seq;

  logic        clk = 1'b0;
  logic        rst, start, shift_en, busy, done, zero_flag, op_req, op_valid, alu_z;
  logic [7:0]  len;
  logic [23:0] result, op_a, op_b, alu_a, alu_b, alu_c;
  logic [2:0]  alu_ctrl;
  logic [47:0] mul_full;

  int err_cnt = 0;
  int chk_cnt = 0;

  logic [23:0] a_q[$];
  logic [23:0] b_q[$];
  logic [2:0]  trace[$];
  logic [23:0] obs_result;
  logic        obs_z;

  always #5 clk = ~clk;

  dot_product_seq #(.DATA_W(24), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .shift_en(shift_en),
    .busy(busy), .done(done), .result(result), .zero_flag(zero_flag),
    .op_req(op_req), .op_valid(op_valid), .op_a(op_a), .op_b(op_b),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_z(alu_z)
  );

  // Behavioural model of the external combinational ALU.
  always_comb begin
    mul_full = {24'd0, alu_a} * {24'd0, alu_b};
    case (alu_ctrl)
      3'd1:    alu_c = alu_a + alu_b;
      3'd2:    alu_c = mul_full[23:0];
      3'd3:    alu_c = alu_a - alu_b;
      3'd4:    alu_c = alu_a >> 8;
      3'd5:    alu_c = alu_a << 8;
      default: alu_c = 24'd0;
    endcase
    alu_z = (alu_c == 24'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] ref_dot(input int n, input bit sh);
    logic [23:0] s;
    logic [47:0] p;
    s = 24'd0;
    for (int i = 0; i < n; i++) begin
      p = 48'(a_q[i]) * 48'(b_q[i]);
      s = s + p[23:0];
    end
    if (sh) s = s >> 8;
    return s;
  endfunction

  task automatic run_job(input string tag, input int n, input bit sh, input int stall, input bit poke);
    int exp_done, idx, stall_left, dones, done_at, req_cycles, hold_bad;
    bit xfer;
    logic [23:0] exp_r, prev_r;
    logic prev_z;
    exp_done = 3*n + 2 + (sh ? 1 : 0) + stall;
    idx = 0; stall_left = stall; dones = 0; done_at = -1; req_cycles = 0; hold_bad = 0;
    exp_r = ref_dot(n, sh);
    trace.delete();
    @(negedge clk);
    prev_r = result; prev_z = zero_flag;
    start = 1'b1; len = 8'(n); shift_en = sh; op_valid = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0; len = 8'($urandom); shift_en = 1'($urandom);
    for (int cyc = 1; cyc <= exp_done + 3; cyc++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        if (done_at < 0) done_at = cyc - 1;
        prev_r = result; prev_z = zero_flag;
      end else if (result !== prev_r || zero_flag !== prev_z) begin
        hold_bad++;
      end
      if (cyc <= exp_done) trace.push_back(alu_ctrl);
      if (cyc == 1) chk({tag, ":busy"}, 32'(busy), 32'd1);
      xfer = 1'b0;
      if (op_req) begin
        req_cycles++;
        if (stall_left > 0) begin
          stall_left--;
          op_valid = 1'b0;
          chk({tag, ":stall_alu"}, 32'(alu_ctrl), 32'd0);
        end else begin
          op_valid = 1'b1;
          xfer = 1'b1;
        end
      end else begin
        op_valid = 1'($urandom);
      end
      op_a = (idx < n) ? a_q[idx] : 24'($urandom);
      op_b = (idx < n) ? b_q[idx] : 24'($urandom);
      start = poke && (cyc == 4);
      if (start) len = 8'd7;
      @(posedge clk);
      if (xfer) idx++;
    end
    @(negedge clk);
    start = 1'b0;
    chk({tag, ":done_at"}, 32'(done_at), 32'(exp_done));
    chk({tag, ":dones"}, 32'(dones), 32'd1);
    chk({tag, ":xfers"}, 32'(idx), 32'(n));
    chk({tag, ":req_cyc"}, 32'(req_cycles), 32'(n + stall));
    chk({tag, ":result"}, 32'(result), 32'(exp_r));
    chk({tag, ":zflag"}, 32'(zero_flag), 32'(exp_r == 24'd0));
    chk({tag, ":hold"}, 32'(hold_bad), 32'd0);
    chk({tag, ":idle"}, 32'(busy), 32'd0);
    obs_result = result;
    obs_z = zero_flag;
  endtask

  task automatic load2(input logic [23:0] a0, input logic [23:0] b0,
                       input logic [23:0] a1, input logic [23:0] b1);
    a_q.delete(); b_q.delete();
    a_q.push_back(a0); b_q.push_back(b0);
    a_q.push_back(a1); b_q.push_back(b1);
  endtask

  logic [2:0] exp_tr [11];
  int n_r, st_r, dones_after;
  bit sh_r;

  initial begin
    exp_tr = '{3'd6, 3'd0, 3'd2, 3'd1, 3'd0, 3'd2, 3'd1, 3'd0, 3'd2, 3'd1, 3'd0};
    rst = 1'b1; start = 1'b0; len = 8'd0; shift_en = 1'b0;
    op_valid = 1'b0; op_a = 24'd0; op_b = 24'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_ctrl", 32'(alu_ctrl), 32'd0);
    chk("rst_req", 32'(op_req), 32'd0);
    rst = 1'b0;

    // len=3 reference case with ALU opcode trace
    a_q = '{24'd1, 24'd2, 24'd3};
    b_q = '{24'd4, 24'd5, 24'd6};
    run_job("len3", 3, 1'b0, 0, 1'b0);
    chk("len3_val", 32'(obs_result), 32'd32);
    for (int i = 0; i < 11; i++) chk($sformatf("len3_tr%0d", i), 32'(trace[i]), 32'(exp_tr[i]));

    a_q.delete(); b_q.delete();
    run_job("len0", 0, 1'b0, 0, 1'b0);
    chk("len0_z", 32'(obs_z), 32'd1);
    run_job("len0s", 0, 1'b1, 0, 1'b0);

    a_q = '{24'h000300}; b_q = '{24'h000200};
    run_job("shift", 1, 1'b1, 0, 1'b0);
    chk("shift_val", 32'(obs_result), 32'h000600);

    // abort mid-ACC of a len=4 job
    @(negedge clk);
    start = 1'b1; len = 8'd4; shift_en = 1'b0; op_valid = 1'b1; op_a = 24'd3; op_b = 24'd5;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("abort_in_acc", 32'(alu_ctrl), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_zflag", 32'(zero_flag), 32'd0);
    chk("abort_alu", 32'({op_req, alu_ctrl, alu_a | alu_b}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dones_after = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) dones_after++;
    end
    chk("abort_nodone", 32'(dones_after), 32'd0);
    a_q = '{24'd7}; b_q = '{24'd6};
    run_job("post_rst", 1, 1'b0, 0, 1'b0);
    chk("post_rst_val", 32'(obs_result), 32'd42);

    load2(24'hFFFFFF, 24'd1, 24'd1, 24'd1);
    run_job("wrap", 2, 1'b0, 0, 1'b0);
    chk("wrap_z", 32'(obs_z), 32'd1);
    a_q = '{24'h800000}; b_q = '{24'd2};
    run_job("trunc", 1, 1'b0, 0, 1'b0);
    chk("trunc_val", 32'(obs_result), 32'd0);

    // backpressure in the first fetch plus an ignored start while busy
    load2(24'd9, 24'd11, 24'd13, 24'd17);
    run_job("stall", 2, 1'b0, 4, 1'b1);
    chk("stall_val", 32'(obs_result), 32'd320);

    for (int j = 0; j < 25; j++) begin
      n_r = $urandom_range(0, 6);
      sh_r = 1'($urandom);
      st_r = (n_r == 0) ? 0 : $urandom_range(0, 3);
      a_q.delete(); b_q.delete();
      for (int k = 0; k < n_r; k++) begin
        a_q.push_back(($urandom_range(0, 1) == 0) ? 24'($urandom) : 24'($urandom_range(0, 4095)));
        b_q.push_back(($urandom_range(0, 1) == 0) ? 24'($urandom) : 24'($urandom_range(0, 4095)));
      end
      run_job($sformatf("rnd%0d", j), n_r, sh_r, st_r, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/dot_product_seq.md
# dot_product_seq

Sequencer that drives the 24-bit combinational ALU to compute a fixed-point dot product of two operand streams for the matrix-multiplication datapath. It accepts a start command with a vector length and fetches operand pairs over a request/valid handshake. It issues ZERO/MUL/ADD/SFTR opcodes to the ALU and captures its result and zero flag. The final 24-bit sum is returned with a one-cycle done pulse.

## Interface
- DATA_W, 24, operand/ALU data width (fixed to ALU width)
- LEN_W, 8, width of vector-length field
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- start  in  1  command strobe; sampled only in IDLE
- len  in  LEN_W  number of element pairs (0 legal)
- shift_en  in  1  apply final SFTR (>>8 fixed-point rescale)
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- result  out  DATA_W  final dot product, held until next done
- zero_flag  out  1  ALU Z of last accumulator update, held with result
- op_req  out  1  requesting next operand pair
- op_valid  in  1  operand pair present
- op_a, op_b  in  DATA_W  operand pair
- alu_ctrl  out  3  ALU opcode: ADD=1, MUL=2, SUB=3, SFTR=4, SFTL=5, ZERO=6, 0=NOP
- alu_a, alu_b  out  DATA_W  ALU operands
- alu_c  in  DATA_W  ALU result (combinational, same cycle)
- alu_z  in  1  ALU zero flag (combinational, same cycle)

## Operation
- States: IDLE, CLR, FETCH, MUL, ACC, SHIFT, FIN.
- IDLE: alu_ctrl=0. start=1 → latch len into cnt, latch shift_en, busy<=1, → CLR.
- CLR: alu_ctrl=ZERO; acc<=alu_c, accz<=alu_z. cnt==0 → (shift ? SHIFT : FIN), else → FETCH.
- FETCH: op_req=1, alu_ctrl=0. op_valid=1 → a_reg<=op_a, b_reg<=op_b, → MUL; else stay.
- MUL: alu_ctrl=MUL, alu_a=a_reg, alu_b=b_reg; prod<=alu_c. → ACC.
- ACC: alu_ctrl=ADD, alu_a=acc, alu_b=prod; acc<=alu_c, accz<=alu_z, cnt<=cnt-1. When cnt==1 → (shift ? SHIFT : FIN), else → FETCH.
- SHIFT: alu_ctrl=SFTR, alu_a=acc; acc<=alu_c, accz<=alu_z. → FIN.
- FIN: alu_ctrl=0; result<=acc, zero_flag<=accz, done<=1, busy<=0. → IDLE.
- The sequencer drives alu_a/alu_b to 0 in every state that does not use them.
- op_req is a combinational decode of state==FETCH. A transfer occurs on an edge with op_req&op_valid.
- All arithmetic is modulo 2^24. Products keep the low 24 bits (ALU truncation). Sums wrap. No overflow flag.
- len, shift_en and op_a/op_b are ignored outside their sampling points. The sequencer ignores start while busy.

## Timing
- Reset (async, any state): state=IDLE. busy, done, result, zero_flag, op_req, alu_ctrl, alu_a, alu_b, acc, prod, cnt, accz all 0. An aborted command produces no done.
- Edge e0 samples start. With op_valid held high, done=1 after edge e(3N+2), or e(3N+3) with shift_en. N=len.
- len=0: done after e2 (e3 with shift_en). op_req never asserts.
- Each cycle op_valid is low in FETCH adds one cycle. The ALU is idle (alu_ctrl=0) during stalls.
- done is high exactly one cycle. busy falls on the same edge done rises. A start in the done cycle is accepted (state is IDLE).
- result/zero_flag change only on the done edge.

## Test plan
- Reset: assert rst mid-ACC of a len=4 job → all outputs 0 immediately. No done follows. A subsequent len=1 job (a=7, b=6) → result=42.
- len=3, a={1,2,3}, b={4,5,6}, op_valid=1, shift_en=0 → result=32, zero_flag=0, done after e11. alu_ctrl sequence 6,0,2,1,0,2,1,0,2,1,0.
- len=0, shift_en=0 → result=0, zero_flag=1, done after e2, op_req never high.
- shift_en=1, len=1, a=0x000300, b=0x000200 → product 0x060000, result=0x000600, done after e6.
- Wrap: len=2, a={0xFFFFFF,0x000001}, b={1,1} → result=0x000000, zero_flag=1. Truncation: len=1, a=0x800000, b=2 → result=0.
- Backpressure: len=2, op_valid low 4 cycles in the first FETCH → op_req held, alu_ctrl=0 throughout the stall, done delayed by exactly 4 cycles. A start pulse while busy is ignored (only one done).
